// File: rtl/bin_to_bcd.sv
// bin_to_bcd: sequential double-dabble converter, 14-bit binary to four BCD digits plus overflow.
// Define BIN2BCD_SAT_EN to saturate the digits to 9999 on overflow instead of keeping Value mod 10000.
module bin_to_bcd (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [13:0] value_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        overflow_o,
    output logic [3:0]  bcd3_o,
    output logic [3:0]  bcd2_o,
    output logic [3:0]  bcd1_o,
    output logic [3:0]  bcd0_o
);
    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;
    state_t      state_q, state_d;
    logic [13:0] sh_q, sh_d;
    logic [19:0] scr_q, scr_d, adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        ovf_q, ovf_d, done_q, done_d;
    always_comb begin
        for (int i = 0; i < 5; i++)
            adj[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    end
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                sh_d    = value_i;
                scr_d   = '0;
                cnt_d   = 4'd13;
                state_d = CONV;
            end
            CONV: begin
                {scr_d, sh_d} = {adj[18:0], sh_q, 1'b0};
                cnt_d         = cnt_q - 4'd1;
                state_d       = cnt_q == 4'd0 ? FINISH : CONV;
            end
            FINISH: begin
                ovf_d   = |scr_q[19:16];
`ifdef BIN2BCD_SAT_EN
                out_d   = ovf_d ? 16'h9999 : scr_q[15:0];
`else
                out_d   = scr_q[15:0];
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end
    assign busy_o     = state_q != IDLE;
    assign done_o     = done_q;
    assign overflow_o = ovf_q;
    assign {bcd3_o, bcd2_o, bcd1_o, bcd0_o} = out_q;
endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: randomized self-checking bench for bin_to_bcd against an arithmetic decimal model.
// Honours BIN2BCD_SAT_EN the same way as the design.
module tb_bin_to_bcd;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [13:0] value = '0;
    logic        busy, done, ovf;
    logic [3:0]  d3, d2, d1, d0;
    int checks = 0, failures = 0;

    bin_to_bcd dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .value_i(value),
        .busy_o(busy), .done_o(done), .overflow_o(ovf),
        .bcd3_o(d3), .bcd2_o(d2), .bcd1_o(d1), .bcd0_o(d0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_bcd(input int v);
        int m = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) return 16'h9999;
`endif
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] got_bcd();
        return {d3, d2, d1, d0};
    endfunction

    // Caller is at a negedge; returns at the negedge right after the sampling edge.
    task automatic pulse_start(input logic [13:0] v);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = 14'($urandom);
    endtask

    // cyc = negedges since pulse_start returned until done seen (-1 if never); nb = busy cycles seen.
    task automatic wait_done(output int cyc, output int nb);
        cyc = -1;
        nb  = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                cyc = c;
                break;
            end
            value = 14'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (got_bcd() !== 16'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0000", got_bcd()); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known();
        int cyc, nb;
        pulse_start(14'd1234);
        wait_done(cyc, nb);
        checks++; if (cyc != 15) begin failures++; $display("FAIL known_latency got=%0d exp=15", cyc); end
        checks++; if (nb != 15) begin failures++; $display("FAIL known_busy got=%0d exp=15", nb); end
        checks++; if (got_bcd() !== 16'h1234) begin failures++; $display("FAIL known_bcd got=%h exp=1234", got_bcd()); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL known_ovf got=%b exp=0", ovf); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL known_done_pulse got=%b exp=0", done); end
        checks++; if (got_bcd() !== 16'h1234) begin failures++; $display("FAIL known_hold got=%h exp=1234", got_bcd()); end
    endtask

    task automatic test_back_to_back();
        int cyc, nb;
        pulse_start(14'd0);
        wait_done(cyc, nb);
        checks++; if (got_bcd() !== 16'h0 || ovf !== 1'b0) begin failures++; $display("FAIL b2b_first got=%h/%b exp=0000/0", got_bcd(), ovf); end
        pulse_start(14'd9999);
        wait_done(cyc, nb);
        checks++; if (cyc != 15) begin failures++; $display("FAIL b2b_latency got=%0d exp=15", cyc); end
        checks++; if (got_bcd() !== 16'h9999 || ovf !== 1'b0) begin failures++; $display("FAIL b2b_second got=%h/%b exp=9999/0", got_bcd(), ovf); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int cyc, nb;
        int vals[3] = '{16383, 10000, 9999};
        foreach (vals[i]) begin
            pulse_start(14'(vals[i]));
            wait_done(cyc, nb);
            checks++; if (ovf !== (vals[i] > 9999)) begin failures++; $display("FAIL ovf_flag v=%0d got=%b exp=%b", vals[i], ovf, vals[i] > 9999); end
            checks++; if (got_bcd() !== model_bcd(vals[i])) begin failures++; $display("FAIL ovf_bcd v=%0d got=%h exp=%h", vals[i], got_bcd(), model_bcd(vals[i])); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy();
        int dones = 0;
        pulse_start(14'd42);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge clk);
            if (done) dones++;
            start = (c == 2 || c == 14);
            value = 14'd7;
        end
        start = 1'b0;
        checks++; if (dones != 1) begin failures++; $display("FAIL ignore_dones got=%0d exp=1", dones); end
        checks++; if (got_bcd() !== 16'h0042) begin failures++; $display("FAIL ignore_bcd got=%h exp=0042", got_bcd()); end
    endtask

    task automatic test_reset_abort();
        int dones = 0, cyc, nb;
        pulse_start(14'd5678);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (got_bcd() !== 16'h0 || busy !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL abort_clear got=%h/%b/%b exp=0000/0/0", got_bcd(), busy, ovf); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", dones); end
        pulse_start(14'd90);
        wait_done(cyc, nb);
        checks++; if (got_bcd() !== 16'h0090 || cyc != 15) begin failures++; $display("FAIL abort_next got=%h/%0d exp=0090/15", got_bcd(), cyc); end
        @(negedge clk);
    endtask

    task automatic test_start_reset();
        int hits = 0;
        rst   = 1'b1;
        start = 1'b1;
        value = 14'd321;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy || done) hits++;
            @(negedge clk);
        end
        checks++; if (hits != 0) begin failures++; $display("FAIL start_reset_activity got=%0d exp=0", hits); end
    endtask

    task automatic test_random();
        int cyc, nb, v;
        for (int n = 0; n < 25; n++) begin
            v = (n % 4 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 16383));
            pulse_start(14'(v));
            wait_done(cyc, nb);
            checks++;
            if (cyc != 15 || nb != 15 || got_bcd() !== model_bcd(v) || ovf !== (v > 9999)) begin
                failures++;
                $display("FAIL random v=%0d got=%h/%b/%0d/%0d exp=%h/%b/15/15", v, got_bcd(), ovf, cyc, nb, model_bcd(v), v > 9999);
            end
            if (n % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_known();
        test_back_to_back();
        test_overflow();
        test_ignore_busy();
        test_reset_abort();
        test_start_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 Start  input  1  conversion request, sampled on rising Clk edge.
REQ-004 Value  input  14  unsigned binary operand, 0..16383, sampled with Start.
REQ-005 Busy  output  1  high while a conversion is in progress.
REQ-006 Done  output  1  single-cycle pulse marking a new result.
REQ-007 Overflow  output  1  last accepted Value exceeded 9999.
REQ-008 BCD3, BCD2, BCD1, BCD0  output  4 each  thousands, hundreds, tens and units digits, each 0..9; feed the seven-segment driver digit inputs directly.

Function
REQ-009 The block SHALL implement a three-state FSM: IDLE, CONV, FINISH.
REQ-010 In IDLE with Start=1 and Reset=0, the block SHALL capture Value into a 14-bit shift register, clear a 20-bit (5-digit) BCD scratch register, load a 4-bit iteration counter with 13, and enter CONV.
REQ-011 Each CONV cycle SHALL add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit (double dabble).
REQ-012 CONV SHALL last exactly 14 cycles; when the counter reaches 0 the FSM SHALL enter FINISH.
REQ-013 In FINISH the block SHALL register BCD3..BCD0 and Overflow, assert Done for that one cycle, and return to IDLE.
REQ-014 Latency: Start sampled at edge k -> Done=1 and new BCD outputs visible in the cycle following edge k+15.
REQ-015 Busy SHALL be high for exactly 15 cycles (all of CONV plus FINISH) and low in IDLE.
REQ-016 Start while Busy=1 (including the FINISH cycle) SHALL be ignored, with no queuing.
REQ-017 Start in the cycle after Done SHALL be accepted normally (back-to-back throughput of one result per 16 cycles).
REQ-018 BCD3..BCD0 and Overflow SHALL hold their last values between Done pulses.
REQ-019 Overflow SHALL be 1 when scratch digit 4 (ten-thousands) is nonzero at FINISH, otherwise 0.
REQ-020 Value is only sampled on an accepted Start; changes at any other time SHALL have no effect.

Reset
REQ-021 When Reset=1 at a rising edge, the FSM SHALL go to IDLE, Busy=0, Done=0, Overflow=0, and BCD3..BCD0=0.
REQ-022 Reset SHALL take priority over Start in the same cycle; that Start is discarded.
REQ-023 Reset during CONV or FINISH SHALL abort the conversion with no Done pulse, and the partial result SHALL never reach the outputs.

Configuration
REQ-024 Macro BIN2BCD_SAT_EN defined: on overflow, BCD3..BCD0 SHALL be forced to 9,9,9,9 at FINISH.
REQ-025 Macro BIN2BCD_SAT_EN undefined: on overflow, BCD3..BCD0 SHALL carry the low four decimal digits (Value mod 10000).
REQ-026 Overflow, latency and handshake SHALL be identical in both builds.

Verification
REQ-027 Reset, then Start with Value=1234 -> Busy for 15 cycles, Done at k+15, BCD=1,2,3,4, Overflow=0.
REQ-028 Value=0, then back-to-back Value=9999 Start in the cycle after Done -> 0,0,0,0 then 9,9,9,9, Overflow=0 both times.
REQ-029 Value=16383 -> Overflow=1; BCD=9,9,9,9 with BIN2BCD_SAT_EN, else 6,3,8,3.
REQ-030 Value=42 accepted, Start with Value=7 pulsed at conversion cycles 3 and 15 -> exactly one Done, result 0,0,4,2.
REQ-031 Value=5678 accepted, Reset at conversion cycle 8, then Start with Value=90 -> no Done before the reset, outputs 0 after reset, second result 0,0,9,0.
REQ-032 Start and Reset asserted in the same cycle -> Busy stays 0, no Done for 20 cycles.
